// File: rtl/restoring_divider_pkg.sv
// Shared constants and state type for the restoring divider.
`timescale 1ns/1ps
package divider_pkg;

    localparam int WIDTH      = 16;
    localparam int ITER_COUNT = WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/restoring_divider_sub17.sv
// 17-bit ripple subtractor: a - b computed as a + ~b + 1 through a chain of full-adder cells.
`timescale 1ns/1ps
module sub17 (
    input  logic [16:0] a,
    input  logic [16:0] b,
    output logic [16:0] diff,
    output logic        borrow
);

    // Carry-out of the top cell is the inverse of the borrow.
    always_comb begin
        logic c;
        logic bn;
        diff = '0;
        c    = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bn      = ~b[i];
            diff[i] = a[i] ^ bn ^ c;
            c       = (a[i] & bn) | (c & (a[i] ^ bn));
        end
        borrow = ~c;
    end

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, with divide-by-zero bypass.
`timescale 1ns/1ps
module restoring_divider #(
    parameter int WIDTH = divider_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    import divider_pkg::*;

    state_t state;
    state_t state_next;

    logic [WIDTH:0]     r;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   divisor_q;
    logic [3:0]         count;
    logic [2*WIDTH:0]   rq_shift;
    logic [WIDTH:0]     r_shift;
    logic [WIDTH:0]     trial;
    logic               borrow;
    logic [WIDTH:0]     r_next;
    logic [WIDTH-1:0]   q_next;
    logic               accept;
    logic               last_iter;

    assign rq_shift  = {r, q} << 1;
    assign r_shift   = rq_shift[2*WIDTH:WIDTH];
    assign accept    = (state == ST_IDLE) && start;
    assign last_iter = (count == 4'(ITER_COUNT - 1));
    assign busy      = (state == ST_RUN);

    sub17 u_sub (
        .a      (r_shift),
        .b      ({1'b0, divisor_q}),
        .diff   (trial),
        .borrow (borrow)
    );

    // A borrow means the trial went negative, so the shifted remainder is restored.
    assign r_next = borrow ? r_shift : trial;
    assign q_next = rq_shift[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = (divisor == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (last_iter) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Results load when DONE is entered; done/div_zero follow one cycle later so they
    // rise together with results already stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r         <= '0;
            q         <= '0;
            divisor_q <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done <= (state == ST_DONE);
            if (accept) begin
                divisor_q <= divisor;
                r         <= '0;
                q         <= dividend;
                count     <= '0;
                div_zero  <= 1'b0;
                if (divisor == '0) begin
                    quotient  <= '1;
                    remainder <= dividend;
                end
            end else if (state == ST_RUN) begin
                r     <= r_next;
                q     <= q_next;
                count <= count + 4'd1;
                if (last_iter) begin
                    quotient  <= q_next;
                    remainder <= r_next[WIDTH-1:0];
                end
            end else if ((state == ST_DONE) && (divisor_q == '0)) begin
                div_zero <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and randomized checks for restoring_divider: results, latency, Busy width, div-zero, reset abort.
`timescale 1ns/1ps
module tb_restoring_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        div_zero;

    int total;
    int bad;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_q;
        logic [15:0] exp_r;
        logic        exp_dz;
        int          exp_lat;
        int          exp_busy;
    } vec_t;

    vec_t vecs[9];

    restoring_divider #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Called at posedge+1; returns cycles from the accepting edge to Done and Busy-high sample count.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, output int lat, output int busy_cycles);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start       = 1'b0;
        lat         = 0;
        busy_cycles = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bcyc;
        int ndone;
        logic [15:0] ra;
        logic [15:0] rb;

        total = 0;
        bad   = 0;

        vecs[0] = '{16'd100,   16'd7,      16'd14,     16'd2,      1'b0, 17, 16};
        vecs[1] = '{16'hFFFF,  16'h0001,   16'hFFFF,   16'h0000,   1'b0, 17, 16};
        vecs[2] = '{16'hFFFF,  16'hFFFF,   16'h0001,   16'h0000,   1'b0, 17, 16};
        vecs[3] = '{16'd5,     16'd9,      16'd0,      16'd5,      1'b0, 17, 16};
        vecs[4] = '{16'h1234,  16'h0000,   16'hFFFF,   16'h1234,   1'b1, 1,  0};
        vecs[5] = '{16'd10,    16'd3,      16'd3,      16'd1,      1'b0, 17, 16};
        vecs[6] = '{16'd0,     16'd5,      16'd0,      16'd0,      1'b0, 17, 16};
        vecs[7] = '{16'h8000,  16'd3,      16'd10922,  16'd2,      1'b0, 17, 16};
        vecs[8] = '{16'd1000,  16'd1000,   16'd1,      16'd0,      1'b0, 17, 16};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        checkOutput("reset_quotient",  32'(quotient),  32'h0);
        checkOutput("reset_remainder", 32'(remainder), 32'h0);
        checkOutput("reset_busy",      32'(busy),      32'h0);
        checkOutput("reset_done",      32'(done),      32'h0);
        checkOutput("reset_divzero",   32'(div_zero),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, lat, bcyc);
            checkOutput($sformatf("vec%0d_latency", i),  32'(lat),       32'(vecs[i].exp_lat));
            checkOutput($sformatf("vec%0d_busy", i),     32'(bcyc),      32'(vecs[i].exp_busy));
            checkOutput($sformatf("vec%0d_quotient", i), 32'(quotient),  32'(vecs[i].exp_q));
            checkOutput($sformatf("vec%0d_remainder", i),32'(remainder), 32'(vecs[i].exp_r));
            checkOutput($sformatf("vec%0d_divzero", i),  32'(div_zero),  32'(vecs[i].exp_dz));
            @(posedge clk); #1;
            checkOutput($sformatf("vec%0d_done_pulse", i), 32'(done), 32'h0);
            checkOutput($sformatf("vec%0d_hold_q", i),   32'(quotient),  32'(vecs[i].exp_q));
        end

        // Start pulses and operand changes during RUN must not disturb the running division.
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 3) begin
                start    = 1'b1;
                dividend = 16'd9;
                divisor  = 16'd2;
            end else if (c == 4) begin
                start    = 1'b0;
                dividend = 16'hAAAA;
                divisor  = 16'h0000;
            end
            @(posedge clk); #1;
            if (done) ndone++;
        end
        checkOutput("ignore_start_done_count", 32'(ndone),     32'd1);
        checkOutput("ignore_start_quotient",   32'(quotient),  32'd10);
        checkOutput("ignore_start_remainder",  32'(remainder), 32'd0);

        // Asynchronous reset in the middle of RUN.
        start    = 1'b1;
        dividend = 16'd200;
        divisor  = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        checkOutput("abort_busy_before", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_quotient",  32'(quotient),  32'h0);
        checkOutput("abort_remainder", 32'(remainder), 32'h0);
        checkOutput("abort_busy",      32'(busy),      32'h0);
        checkOutput("abort_done",      32'(done),      32'h0);
        checkOutput("abort_divzero",   32'(div_zero),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        checkOutput("abort_no_done", 32'(ndone), 32'd0);
        applyStimulus(16'd200, 16'd3, lat, bcyc);
        checkOutput("after_abort_latency",   32'(lat),       32'd17);
        checkOutput("after_abort_quotient",  32'(quotient),  32'd66);
        checkOutput("after_abort_remainder", 32'(remainder), 32'd2);
        @(posedge clk); #1;

        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom_range(1, 65535));
            applyStimulus(ra, rb, lat, bcyc);
            checkOutput("sweep_identity", 32'(quotient) * 32'(rb) + 32'(remainder), 32'(ra));
            checkOutput("sweep_rem_lt_div", 32'(remainder < rb), 32'h1);
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
